// File: rtl/mfp_ahb_intc.sv
// mfp_ahb_intc -- AHB-Lite interrupt controller for the MIPSfpga SI_Int pin.
//
// Collects N_IRQ asynchronous interrupt sources, synchronises them, latches
// them as level or edge events with per-channel polarity, masks them with an
// enable register and presents a registered request plus the 1-based index of
// the highest-priority (lowest-numbered) active channel.
//
// Register map (word offsets, index taken from HADDR[BASE_SEL_BITS+1:2]):
//   0x00 STATUS   RO   PENDING & ENABLE
//   0x04 PENDING  R/W1C (W1C ignored on level channels)
//   0x08 ENABLE   RW
//   0x0C MODE     RW   1 = edge, 0 = level
//   0x10 POLARITY RW   1 = active high / rising, 0 = active low / falling
//   0x14 VECTOR   RO   INT_Vector zero-extended
//   others read 0, writes ignored. Bits [31:N_IRQ] read 0.
//
// Ports:
//   HCLK, SI_Reset          clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HWDATA,
//   HREADY                  AHB-Lite slave inputs (HSIZE ignored)
//   HRDATA, HREADYOUT, HRESP AHB-Lite slave outputs (zero wait, always OKAY)
//   IRQ_In[N_IRQ]           asynchronous interrupt sources
//   intc_irq                registered OR of STATUS
//   INT_Vector[6]           registered lowest active STATUS index + 1, 0 = none

module mfp_ahb_intc #(
  parameter int N_IRQ         = 8,
  parameter int BASE_SEL_BITS = 3
) (
  input  logic                 HCLK,
  input  logic                 SI_Reset,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  input  logic [N_IRQ-1:0]     IRQ_In,
  output logic                 intc_irq,
  output logic [5:0]           INT_Vector
);

  localparam int IW = BASE_SEL_BITS;

  localparam logic [IW-1:0] REG_STATUS   = IW'(0);
  localparam logic [IW-1:0] REG_PENDING  = IW'(1);
  localparam logic [IW-1:0] REG_ENABLE   = IW'(2);
  localparam logic [IW-1:0] REG_MODE     = IW'(3);
  localparam logic [IW-1:0] REG_POLARITY = IW'(4);
  localparam logic [IW-1:0] REG_VECTOR   = IW'(5);

  // Bus bookkeeping
  logic          sel_q;
  logic          write_q;
  logic [IW-1:0] addr_q;
  logic          wr_en;
  logic [N_IRQ-1:0] wdata;

  // Programmer-visible state
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] enable;
  logic [N_IRQ-1:0] mode;
  logic [N_IRQ-1:0] polarity;

  // Input conditioning
  logic [N_IRQ-1:0] sync1;
  logic [N_IRQ-1:0] sync2;
  logic [N_IRQ-1:0] hist;
  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] hist_active;
  logic [N_IRQ-1:0] edge_set;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] status;
  logic [5:0]       vector_next;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Inputs that are deliberately not decoded (size, sequential/nonseq
  // distinction, unmapped address and data bits).
  logic unused_ok;
  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR, HWDATA};

  // Address phase capture. The slave never stalls, so the data phase always
  // ends on the next edge where HREADY is high.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // flops sample pre-edge values and simulation matches the synthesised logic.
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (HREADY) begin
      sel_q   <= HSEL & HTRANS[1];
      write_q <= HSEL & HTRANS[1] & HWRITE;
      addr_q  <= HADDR[BASE_SEL_BITS+1:2];
    end
  end

  assign wr_en = write_q & HREADY;
  assign wdata = HWDATA[N_IRQ-1:0];

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      enable   <= '0;
      mode     <= '0;
      polarity <= '0;
    end else if (wr_en) begin
      if (addr_q == REG_ENABLE)   enable   <= wdata;
      if (addr_q == REG_MODE)     mode     <= wdata;
      if (addr_q == REG_POLARITY) polarity <= wdata;
    end
  end

  // Two-flop synchroniser plus a history flop for edge detection.
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= IRQ_In;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Polarity is applied to both the current and the history sample with the
  // current POLARITY, so a polarity change alone never fabricates an edge.
  assign active      = ~(sync2 ^ polarity);
  assign hist_active = ~(hist  ^ polarity);
  assign edge_set    = active & ~hist_active;
  assign w1c         = (wr_en && addr_q == REG_PENDING) ? wdata : '0;

  // Edge channels: sticky, cleared by W1C, a new edge beats a same-cycle
  // clear. Level channels simply track the conditioned input, which also
  // makes an edge->level switch overwrite the latched bit.
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) pending <= '0;
    else          pending <= (mode & ((pending & ~w1c) | edge_set)) | (~mode & active);
  end

  assign status = pending & enable;

  // Fixed priority: scan from the top so the lowest set index is kept.
  // NOTE: combinational processes assign every output a default first so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    vector_next = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (status[i]) vector_next = 6'(i + 1);
    end
  end

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      intc_irq   <= 1'b0;
      INT_Vector <= '0;
    end else begin
      intc_irq   <= |status;
      INT_Vector <= vector_next;
    end
  end

  // Read data is decoded from the captured address during the data phase.
  always_comb begin
    HRDATA = '0;
    if (sel_q) begin
      case (addr_q)
        REG_STATUS:   HRDATA[N_IRQ-1:0] = status;
        REG_PENDING:  HRDATA[N_IRQ-1:0] = pending;
        REG_ENABLE:   HRDATA[N_IRQ-1:0] = enable;
        REG_MODE:     HRDATA[N_IRQ-1:0] = mode;
        REG_POLARITY: HRDATA[N_IRQ-1:0] = polarity;
        REG_VECTOR:   HRDATA[5:0]       = INT_Vector;
        default:      HRDATA            = '0;
      endcase
    end
  end

endmodule
